// File: rtl/mmio_fifo_csr.sv
// -----------------------------------------------------------------------------
// mmio_fifo_csr
// MMIO-mapped CSR block for a CCI-P AFU. Inside one 16-bit MMIO window it
// holds a data FIFO, a STATUS register, a CTRL register and NUM_USER_REGS
// general-purpose user registers. The AFU top unpacks rx.c0 into the mmio_*
// inputs and packs tx.c2 from the rd_rsp_* outputs.
//
// Register map (offsets from BASE_ADDR, 32-bit word units):
//   +0        FIFO data   write = push, read = pop
//   +2        STATUS      RO  {48'b0, count[7:0], 4'b0, underflow, overflow, full, empty}
//   +4        CTRL        WO  bit0 clear stickies, bit1 flush; reads return 0
//   +6        PEEK        RO  only with MMIO_FIFO_PEEK_EN: mem[rd_ptr] without popping
//   +U+2*i    USER[i]     RW  U = 6, or 8 when MMIO_FIFO_PEEK_EN is defined
// Any other address: writes ignored, reads return 0 with rd_hit = 0.
//
// Optional feature macro: MMIO_FIFO_PEEK_EN
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   mmio_wr_valid   write strobe        mmio_rd_valid  read strobe
//   mmio_addr       word address        mmio_tid       read transaction ID
//   mmio_wdata      write data
//   rd_rsp_valid    one-cycle read response strobe, exactly 1 cycle after the read
//   rd_rsp_tid      echoed TID          rd_rsp_data    response data (zero-extended)
//   rd_hit          read address decoded to a register of this block
//   fifo_empty, fifo_full, fifo_count   registered FIFO occupancy
// -----------------------------------------------------------------------------
module mmio_fifo_csr #(
  parameter int          DATA_W        = 64,
  parameter int          DEPTH         = 8,
  parameter int          NUM_USER_REGS = 4,
  parameter logic [15:0] BASE_ADDR     = 16'h0020
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mmio_wr_valid,
  input  logic                   mmio_rd_valid,
  input  logic [15:0]            mmio_addr,
  input  logic [8:0]             mmio_tid,
  input  logic [63:0]            mmio_wdata,
  output logic                   rd_rsp_valid,
  output logic [8:0]             rd_rsp_tid,
  output logic [63:0]            rd_rsp_data,
  output logic                   rd_hit,
  output logic                   fifo_empty,
  output logic                   fifo_full,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [15:0] OFF_FIFO   = 16'd0;
  localparam logic [15:0] OFF_STATUS = 16'd2;
  localparam logic [15:0] OFF_CTRL   = 16'd4;
`ifdef MMIO_FIFO_PEEK_EN
  localparam logic [15:0] OFF_PEEK   = 16'd6;
  localparam logic [15:0] USER_OFF   = 16'd8;
`else
  localparam logic [15:0] USER_OFF   = 16'd6;
`endif
  localparam logic [15:0]      USER_LIMIT = 16'(NUM_USER_REGS);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] user_regs [NUM_USER_REGS];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic              overflow, underflow;

  // ---------------------------------------------------------------------------
  // Address decode. Addresses below BASE_ADDR wrap to large offsets and miss.
  // ---------------------------------------------------------------------------
  logic [15:0] offset, user_rel;
  logic [3:0]  user_idx;
  logic        sel_fifo, sel_status, sel_ctrl, sel_user;

  assign offset     = mmio_addr - BASE_ADDR;
  assign user_rel   = offset - USER_OFF;
  assign user_idx   = user_rel[4:1];
  assign sel_fifo   = (offset == OFF_FIFO);
  assign sel_status = (offset == OFF_STATUS);
  assign sel_ctrl   = (offset == OFF_CTRL);
  assign sel_user   = (offset >= USER_OFF) && !user_rel[0] &&
                      ({1'b0, user_rel[15:1]} < USER_LIMIT);
`ifdef MMIO_FIFO_PEEK_EN
  logic sel_peek;
  assign sel_peek   = (offset == OFF_PEEK);
`endif

  // ---------------------------------------------------------------------------
  // FIFO events, all judged against the pre-cycle flags. Push+pop on a full
  // FIFO therefore drops the push, and on an empty FIFO underflows the pop.
  // ---------------------------------------------------------------------------
  logic push, pop, push_ok, pop_ok, ctrl_wr, clr, flush;

  assign push    = mmio_wr_valid && sel_fifo;
  assign pop     = mmio_rd_valid && sel_fifo;
  assign push_ok = push && !fifo_full;
  assign pop_ok  = pop && !fifo_empty;
  assign ctrl_wr = mmio_wr_valid && sel_ctrl;
  assign clr     = ctrl_wr && mmio_wdata[0];
  assign flush   = ctrl_wr && mmio_wdata[1];

  logic [CNT_W-1:0] count_nxt;

  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned, which would infer a latch.
  always_comb begin
    count_nxt = fifo_count;
    if (flush)
      count_nxt = '0;
    else if (push_ok && !pop_ok)
      count_nxt = fifo_count + CNT_ONE;
    else if (pop_ok && !push_ok)
      count_nxt = fifo_count - CNT_ONE;
  end

  // ---------------------------------------------------------------------------
  // Read mux, built from pre-cycle state.
  // ---------------------------------------------------------------------------
  logic [63:0] status;
  logic [63:0] rd_data_c;
  logic        rd_hit_c;

  assign status = {48'b0, 8'(fifo_count), 4'b0, underflow, overflow, fifo_full, fifo_empty};

  always_comb begin
    rd_data_c = '0;
    rd_hit_c  = 1'b0;
    if (sel_fifo) begin
      rd_hit_c = 1'b1;
      if (!fifo_empty) rd_data_c[DATA_W-1:0] = mem[rd_ptr];
    end else if (sel_status) begin
      rd_hit_c  = 1'b1;
      rd_data_c = status;
    end else if (sel_ctrl) begin
      rd_hit_c = 1'b1;
`ifdef MMIO_FIFO_PEEK_EN
    end else if (sel_peek) begin
      rd_hit_c = 1'b1;
      if (!fifo_empty) rd_data_c[DATA_W-1:0] = mem[rd_ptr];
`endif
    end else if (sel_user) begin
      rd_hit_c = 1'b1;
      for (int i = 0; i < NUM_USER_REGS; i++)
        if (user_idx == 4'(i)) rd_data_c[DATA_W-1:0] = user_regs[i];
    end
  end

  // ---------------------------------------------------------------------------
  // Control state and read response.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_count   <= '0;
      fifo_empty   <= 1'b1;
      fifo_full    <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
      for (int i = 0; i < NUM_USER_REGS; i++) user_regs[i] <= '0;
      rd_rsp_valid <= 1'b0;
      rd_rsp_tid   <= '0;
      rd_rsp_data  <= '0;
      rd_hit       <= 1'b0;
    end else begin
      fifo_count <= count_nxt;
      fifo_empty <= (count_nxt == '0);
      fifo_full  <= (count_nxt == CNT_FULL);

      // Flush overrides any same-cycle pointer movement.
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
        if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
      end

      // A new sticky event beats a same-cycle clear.
      overflow  <= (overflow  && !clr) || (push && fifo_full);
      underflow <= (underflow && !clr) || (pop  && fifo_empty);

      for (int i = 0; i < NUM_USER_REGS; i++)
        if (mmio_wr_valid && sel_user && user_idx == 4'(i))
          user_regs[i] <= mmio_wdata[DATA_W-1:0];

      rd_rsp_valid <= mmio_rd_valid;
      if (mmio_rd_valid) begin
        rd_rsp_tid  <= mmio_tid;
        rd_rsp_data <= rd_data_c;
        rd_hit      <= rd_hit_c;
      end
    end
  end

  // NOTE: FIFO storage has no reset; the pointers and count alone define
  // which entries are valid, so the array can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= mmio_wdata[DATA_W-1:0];
  end

endmodule

// File: tb/tb_mmio_fifo_csr.sv
// -----------------------------------------------------------------------------
// tb_mmio_fifo_csr
// Self-checking bench for mmio_fifo_csr (DATA_W=64, DEPTH=8, 4 user regs,
// BASE_ADDR=h0020). Directed table, hand sequences for reset mid-operation
// and PEEK, then randomized MMIO traffic against a queue-based model.
// -----------------------------------------------------------------------------
module tb_mmio_fifo_csr;

  localparam int          DEPTH  = 8;
  localparam int          NUM_U  = 4;
  localparam logic [15:0] BASE   = 16'h0020;
`ifdef MMIO_FIFO_PEEK_EN
  localparam bit          PEEK   = 1'b1;
  localparam int          UOFF   = 8;
`else
  localparam bit          PEEK   = 1'b0;
  localparam int          UOFF   = 6;
`endif
  localparam logic [15:0] A_FIFO   = BASE;
  localparam logic [15:0] A_STATUS = BASE + 16'd2;
  localparam logic [15:0] A_CTRL   = BASE + 16'd4;
  localparam logic [15:0] A_PEEK   = BASE + 16'd6;
  localparam logic [15:0] A_USER0  = BASE + 16'(UOFF);
  localparam logic [15:0] A_USER1  = BASE + 16'(UOFF + 2);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mmio_wr_valid = 1'b0;
  logic        mmio_rd_valid = 1'b0;
  logic [15:0] mmio_addr = '0;
  logic [8:0]  mmio_tid = '0;
  logic [63:0] mmio_wdata = '0;
  logic        rd_rsp_valid;
  logic [8:0]  rd_rsp_tid;
  logic [63:0] rd_rsp_data;
  logic        rd_hit;
  logic        fifo_empty;
  logic        fifo_full;
  logic [3:0]  fifo_count;

  mmio_fifo_csr #(
    .DATA_W(64), .DEPTH(DEPTH), .NUM_USER_REGS(NUM_U), .BASE_ADDR(BASE)
  ) dut (
    .clk(clk), .rst(rst),
    .mmio_wr_valid(mmio_wr_valid), .mmio_rd_valid(mmio_rd_valid),
    .mmio_addr(mmio_addr), .mmio_tid(mmio_tid), .mmio_wdata(mmio_wdata),
    .rd_rsp_valid(rd_rsp_valid), .rd_rsp_tid(rd_rsp_tid),
    .rd_rsp_data(rd_rsp_data), .rd_hit(rd_hit),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: FIFO as a queue, flags derived from its size.
  // ---------------------------------------------------------------------------
  logic [63:0] model_q[$];
  logic [63:0] model_user [16];
  logic        model_ovf, model_udf;
  logic [63:0] last_data;
  logic        last_hit;
  logic [8:0]  last_tid;

  task automatic model_reset();
    model_q.delete();
    for (int i = 0; i < 16; i++) model_user[i] = '0;
    model_ovf = 1'b0;
    model_udf = 1'b0;
    last_data = '0;
    last_hit  = 1'b0;
    last_tid  = '0;
  endtask

  task automatic model_step(input logic wr, input logic rd, input logic [15:0] addr,
                            input logic [63:0] wd, output logic [63:0] rdata,
                            output logic hit);
    int off, sz, uidx;
    bit is_user, udf_ev, ovf_ev;
    off     = int'(addr) - int'(BASE);
    sz      = model_q.size();
    uidx    = (off - UOFF) / 2;
    is_user = (off >= UOFF) && (off % 2 == 0) && (uidx < NUM_U);
    rdata = '0;
    hit   = 1'b0;
    if (rd) begin
      if (off == 0) begin
        hit = 1'b1;
        if (sz > 0) rdata = model_q[0];
      end else if (off == 2) begin
        hit = 1'b1;
        rdata = {48'b0, 8'(sz), 4'b0, model_udf, model_ovf, (sz == DEPTH), (sz == 0)};
      end else if (off == 4) begin
        hit = 1'b1;
      end else if (PEEK && off == 6) begin
        hit = 1'b1;
        if (sz > 0) rdata = model_q[0];
      end else if (is_user) begin
        hit = 1'b1;
        rdata = model_user[uidx];
      end
    end
    udf_ev = rd && off == 0 && sz == 0;
    ovf_ev = wr && off == 0 && sz == DEPTH;
    if (rd && off == 0 && sz > 0) void'(model_q.pop_front());
    if (wr && off == 0 && sz < DEPTH) model_q.push_back(wd);
    if (wr && off == 4) begin
      if (wd[0]) begin model_ovf = 1'b0; model_udf = 1'b0; end
      if (wd[1]) model_q.delete();
    end
    if (udf_ev) model_udf = 1'b1;
    if (ovf_ev) model_ovf = 1'b1;
    if (wr && is_user) model_user[uidx] = wd;
  endtask

  // One MMIO cycle: drive at negedge, let the posedge take it, sample #1 later.
  task automatic do_cycle(input logic wr, input logic rd, input logic [15:0] addr,
                          input logic [63:0] wd, input logic [8:0] tid);
    @(negedge clk);
    mmio_wr_valid = wr;
    mmio_rd_valid = rd;
    mmio_addr     = addr;
    mmio_wdata    = wd;
    mmio_tid      = tid;
    @(posedge clk);
    #1;
    mmio_wr_valid = 1'b0;
    mmio_rd_valid = 1'b0;
  endtask

  task automatic check_outputs(input string tag, input logic rd, input logic [8:0] tid,
                               input logic [63:0] exp_data, input logic exp_hit,
                               input int exp_count);
    if (rd) begin
      check({tag, ".rsp_valid"}, 64'(rd_rsp_valid), 64'd1);
      check({tag, ".rsp_tid"},   64'(rd_rsp_tid), 64'(tid));
      check({tag, ".rsp_data"},  rd_rsp_data, exp_data);
      check({tag, ".rd_hit"},    64'(rd_hit), 64'(exp_hit));
      last_data = exp_data;
      last_hit  = exp_hit;
      last_tid  = tid;
    end else begin
      check({tag, ".rsp_idle"},  64'(rd_rsp_valid), 64'd0);
      check({tag, ".data_hold"}, rd_rsp_data, last_data);
      check({tag, ".tid_hold"},  64'(rd_rsp_tid), 64'(last_tid));
    end
    check({tag, ".count"}, 64'(fifo_count), 64'(exp_count));
    check({tag, ".empty"}, 64'(fifo_empty), 64'(exp_count == 0));
    check({tag, ".full"},  64'(fifo_full),  64'(exp_count == DEPTH));
  endtask

  // Model-driven cycle used by the hand sequences and the random phase.
  task automatic model_cycle(input string tag, input logic wr, input logic rd,
                             input logic [15:0] addr, input logic [63:0] wd,
                             input logic [8:0] tid);
    logic [63:0] ed;
    logic        eh;
    model_step(wr, rd, addr, wd, ed, eh);
    do_cycle(wr, rd, addr, wd, tid);
    check_outputs(tag, rd, tid, ed, eh, model_q.size());
  endtask

  // ---------------------------------------------------------------------------
  // Directed vectors with hand-derived expectations.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic        wr;
    logic        rd;
    logic [15:0] addr;
    logic [63:0] wdata;
    logic [63:0] exp_data;
    logic        exp_hit;
    int          exp_count;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic wr, input logic rd, input logic [15:0] addr,
                              input logic [63:0] wd, input logic [63:0] ed,
                              input logic eh, input int ec);
    vec_t v;
    v.wr = wr; v.rd = rd; v.addr = addr; v.wdata = wd;
    v.exp_data = ed; v.exp_hit = eh; v.exp_count = ec;
    vecs.push_back(v);
  endfunction

  initial begin
    logic [63:0] ed;
    logic        eh;
    int          bias;

    model_reset();

    add(0, 1, A_STATUS, 0, 64'h1, 1, 0);
    for (int i = 1; i <= 8; i++) add(1, 0, A_FIFO, 64'(i), 0, 0, i);
    add(1, 0, A_FIFO, 64'd9, 0, 0, 8);
    add(0, 1, A_STATUS, 0, 64'h0806, 1, 8);
    for (int i = 1; i <= 8; i++) add(0, 1, A_FIFO, 0, 64'(i), 1, 8 - i);
    add(0, 1, A_STATUS, 0, 64'h5, 1, 0);
    add(0, 1, A_FIFO, 0, 64'h0, 1, 0);
    add(0, 1, A_STATUS, 0, 64'hD, 1, 0);
    add(1, 0, A_CTRL, 64'h1, 0, 0, 0);
    add(0, 1, A_STATUS, 0, 64'h1, 1, 0);
    add(1, 0, A_FIFO, 64'hA, 0, 0, 1);
    add(1, 0, A_FIFO, 64'hB, 0, 0, 2);
    add(1, 0, A_FIFO, 64'hC, 0, 0, 3);
    add(0, 1, A_STATUS, 0, 64'h0300, 1, 3);
    add(1, 0, A_CTRL, 64'h2, 0, 0, 0);
    add(0, 1, A_FIFO, 0, 64'h0, 1, 0);
    add(0, 1, A_STATUS, 0, 64'h9, 1, 0);
    add(1, 0, A_USER1, 64'hDEAD_BEEF, 0, 0, 0);
    add(0, 1, A_USER1, 0, 64'hDEAD_BEEF, 1, 0);
    add(0, 1, 16'h0040, 0, 64'h0, 0, 0);
    add(0, 1, A_CTRL, 0, 64'h0, 1, 0);
    add(0, 1, A_USER0, 0, 64'h0, 1, 0);
    add(1, 0, A_STATUS, 64'hFFFF, 0, 0, 0);
    add(0, 1, A_STATUS, 0, 64'h9, 1, 0);

    // Reset state while rst is held.
    repeat (3) @(posedge clk);
    #1;
    check("reset.rsp_valid", 64'(rd_rsp_valid), 64'd0);
    check("reset.rsp_tid",   64'(rd_rsp_tid), 64'd0);
    check("reset.rsp_data",  rd_rsp_data, 64'd0);
    check("reset.rd_hit",    64'(rd_hit), 64'd0);
    check("reset.count",     64'(fifo_count), 64'd0);
    check("reset.empty",     64'(fifo_empty), 64'd1);
    check("reset.full",      64'(fifo_full), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[k]) begin
      model_step(vecs[k].wr, vecs[k].rd, vecs[k].addr, vecs[k].wdata, ed, eh);
      do_cycle(vecs[k].wr, vecs[k].rd, vecs[k].addr, vecs[k].wdata, 9'(k + 3));
      check_outputs($sformatf("vec%0d", k), vecs[k].rd, 9'(k + 3),
                    vecs[k].exp_data, vecs[k].exp_hit, vecs[k].exp_count);
    end

    // Push+pop on empty: push accepted, pop underflows and returns 0.
    model_cycle("pp_empty", 1, 1, A_FIFO, 64'h55, 9'h101);
    for (int i = 0; i < 7; i++) model_cycle("fill", 1, 0, A_FIFO, 64'(16 + i), 0);
    check("fill.full", 64'(fifo_full), 64'd1);
    // Push+pop on full: pop accepted (oldest = h55), push dropped.
    model_cycle("pp_full", 1, 1, A_FIFO, 64'h77, 9'h102);
    check("pp_full.data", rd_rsp_data, 64'h55);
    model_cycle("pp_full.status", 0, 1, A_STATUS, 0, 9'h103);
    check("pp_full.status_val", rd_rsp_data, 64'h070C);

    // Reset asserted mid-operation loses the pending response.
    model_cycle("pre_rst.user", 1, 0, A_USER0, 64'h1234, 0);
    @(negedge clk);
    mmio_rd_valid = 1'b1;
    mmio_addr     = A_FIFO;
    mmio_tid      = 9'h1AA;
    @(posedge clk);
    #1;
    mmio_rd_valid = 1'b0;
    check("pre_rst.rsp_valid", 64'(rd_rsp_valid), 64'd1);
    rst = 1'b1;
    #1;
    check("mid_rst.rsp_valid", 64'(rd_rsp_valid), 64'd0);
    check("mid_rst.rsp_data",  rd_rsp_data, 64'd0);
    check("mid_rst.rsp_tid",   64'(rd_rsp_tid), 64'd0);
    check("mid_rst.count",     64'(fifo_count), 64'd0);
    check("mid_rst.empty",     64'(fifo_empty), 64'd1);
    check("mid_rst.full",      64'(fifo_full), 64'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    model_cycle("post_rst.user0", 0, 1, A_USER0, 0, 9'h011);
    check("post_rst.user0_val", rd_rsp_data, 64'd0);
    model_cycle("post_rst.status", 0, 1, A_STATUS, 0, 9'h012);
    check("post_rst.status_val", rd_rsp_data, 64'h1);

    if (PEEK) begin
      model_cycle("peek.empty", 0, 1, A_PEEK, 0, 9'h020);
      model_cycle("peek.push", 1, 0, A_FIFO, 64'h5, 0);
      model_cycle("peek.r1", 0, 1, A_PEEK, 0, 9'h021);
      check("peek.r1_val", rd_rsp_data, 64'h5);
      model_cycle("peek.r2", 0, 1, A_PEEK, 0, 9'h022);
      check("peek.r2_val", rd_rsp_data, 64'h5);
      check("peek.count", 64'(fifo_count), 64'd1);
      model_cycle("peek.pop", 0, 1, A_FIFO, 0, 9'h023);
      check("peek.pop_val", rd_rsp_data, 64'h5);
      model_cycle("peek.status", 0, 1, A_STATUS, 0, 9'h024);
      check("peek.status_val", rd_rsp_data, 64'h1);
    end

    // Randomized traffic: alternating push-heavy and pop-heavy phases.
    for (int n = 0; n < 600; n++) begin
      logic        wr, rd;
      logic [15:0] addr;
      logic [63:0] wd;
      bias = ((n / 75) % 2 == 0) ? 3 : 1;
      wr = ($urandom_range(0, 3) < bias);
      rd = ($urandom_range(0, 3) < 4 - bias);
      wd = {$urandom, $urandom};
      case ($urandom_range(0, 9))
        0, 1, 2, 3: addr = A_FIFO;
        4:          addr = A_STATUS;
        5: begin
          addr = A_CTRL;
          wd   = {62'b0, ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1))};
        end
        6:          addr = A_USER0 + 16'(2 * $urandom_range(0, NUM_U - 1));
        7:          addr = A_PEEK;
        8:          addr = A_USER0 + 16'(2 * NUM_U);
        default:    addr = 16'h001E;
      endcase
      model_cycle($sformatf("rand%0d", n), wr, rd, addr, wd, 9'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule
